kbdmus_loader: RTL
==================

KBDMUS_LOADER -- requirements
Module: kbdmus_loader

Interface
REQ-001 Parameter TIMEOUT, default 4096: idle cycles allowed between keyboard bytes of one frame before the frame is aborted.
REQ-002 Parameter KBD_BYTES, default 5: bytes per keyboard frame (fixed at 5; 40-bit matrix).
REQ-003 fclk  input  1  sole clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 byte_in  input  8  incoming data byte from the SPI slave.
REQ-006 byte_stb  input  1  one-cycle qualifier; byte_in, byte_dst and frame_start are valid this cycle.
REQ-007 byte_dst  input  2  destination: 0=keyboard, 1=mouse X, 2=mouse Y, 3=mouse buttons.
REQ-008 frame_start  input  1  with byte_stb and byte_dst=0: this byte is keyboard byte 0.
REQ-009 kbd_out  output  40  committed key matrix; bit=1 means key pressed.
REQ-010 kbd_stb  output  1  one-cycle pulse: kbd_out has just been updated.
REQ-011 mus_out  output  8  shared mouse data bus.
REQ-012 mus_xstb, mus_ystb, mus_btnstb  output  1 each  one-cycle pulses qualifying mus_out.
REQ-013 err  output  1  one-cycle pulse on a protocol error (stray keyboard byte or timeout).

Function
REQ-014 The keyboard FSM SHALL have states IDLE and COLLECT, plus a 3-bit byte counter.
REQ-015 In any state, a keyboard byte with frame_start SHALL be stored as byte 0, set the counter to 1, and enter COLLECT. A restart in COLLECT discards the partial frame without raising err.
REQ-016 In COLLECT, a keyboard byte without frame_start SHALL be stored at bits [8*n+7:8*n], where n is the counter, and SHALL increment the counter.
REQ-017 On storing byte 4, the FSM SHALL update kbd_out atomically, pulse kbd_stb in the next cycle with kbd_out already valid, and return to IDLE.
REQ-018 kbd_out SHALL change only on a frame commit and SHALL hold its value otherwise.
REQ-019 In IDLE, a keyboard byte without frame_start SHALL be dropped and SHALL pulse err in the next cycle.
REQ-020 In COLLECT, a timeout counter SHALL reset on every keyboard byte. When it reaches TIMEOUT, the FSM SHALL enter IDLE and pulse err; kbd_out is unchanged.
REQ-021 Mouse X and Y bytes SHALL be written to staging registers only, with no output activity; the last write before commit wins.
REQ-022 A button byte SHALL latch the {X, Y, button} staging values into an emit buffer and start the emit sequence.
REQ-023 Emit sequence: on cycle 1, mus_out=X with mus_xstb; on cycle 2, mus_out=Y with mus_ystb; on cycle 3, mus_out=BTN with mus_btnstb. The first cycle follows the button byte by one cycle. At most one mouse strobe is active per cycle.
REQ-024 A button byte arriving during an emit sequence SHALL set a pending flag with a fresh snapshot. The new sequence SHALL start on the cycle after the current cycle 3, with no gap. A later pending snapshot overwrites an earlier one.
REQ-025 mus_out SHALL hold its last driven value between sequences.
REQ-026 Keyboard and mouse paths SHALL operate independently; kbd_stb and any mouse strobe MAY coincide.
REQ-027 byte_dst and frame_start SHALL be ignored when byte_stb=0. frame_start SHALL be ignored for mouse destinations.

Reset
REQ-028 Asserting rst SHALL, asynchronously and at any point mid-frame or mid-sequence, force:
- keyboard FSM to IDLE, counter and timeout counter to 0;
- kbd_out, the keyboard assembly register and all mouse staging and emit registers to 0;
- the pending flag to 0;
- kbd_stb, all mouse strobes and err to 0;
- mus_out to 8'h00.
REQ-029 After rst deasserts, the first byte_stb SHALL be accepted on the first rising fclk edge.

Structure
REQ-030 Package kbdmus_pkg SHALL hold the byte_dst encodings, the keyboard FSM state type and the KBD_BYTES constant.
REQ-031 The mouse emit sequencer (snapshot, pending flag, 3-step strobe counter) SHALL be sub-module kbdmus_mseq; keyboard logic stays in kbdmus_loader.

Verification
REQ-032 Bytes 11,22,33,44,55 to dst 0, first with frame_start -> kbd_out=40'h5544332211, kbd_stb single pulse one cycle after the last byte.
REQ-033 Dst 0 byte without frame_start after reset -> err pulse, kbd_out stays 0, no kbd_stb.
REQ-034 3 keyboard bytes, then TIMEOUT idle cycles -> err pulse, FSM IDLE. A new 5-byte frame then commits correctly.
REQ-035 X=05, Y=FA, BTN=07, then BTN=06 one cycle later -> strobe sequence 05/FA/07, then 05/FA/06 back-to-back.
REQ-036 rst asserted during byte 3 of a frame and during emit cycle 2 -> all outputs 0 immediately, no strobes after release until new input.
REQ-037 Keyboard byte 4 and a mouse BTN byte in consecutive cycles -> kbd_stb and mus_xstb may overlap; both paths complete correctly.

Source files
------------

// File: rtl/kbdmus_pkg.sv
// Shared encodings for the keyboard/mouse byte loader.
// Holds the byte_dst codes, keyboard FSM states, the frame length and the mouse snapshot type.
package kbdmus_pkg;
  localparam int KBD_BYTES = 5;

  typedef enum logic [1:0] {
    DST_KBD  = 2'd0,
    DST_MX   = 2'd1,
    DST_MY   = 2'd2,
    DST_MBTN = 2'd3
  } dst_e;

  typedef enum logic {
    KS_IDLE    = 1'b0,
    KS_COLLECT = 1'b1
  } kstate_e;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] btn;
  } msnap_t;
endpackage

// File: rtl/kbdmus_if.sv
// Byte-strobe input bus and keyboard/mouse result outputs of the loader.
// No backpressure: every byte_stb is consumed in the cycle it appears.
interface kbdmus_if;
  logic [7:0]  byte_in;
  logic        byte_stb;
  logic [1:0]  byte_dst;
  logic        frame_start;
  logic [39:0] kbd_out;
  logic        kbd_stb;
  logic [7:0]  mus_out;
  logic        mus_xstb;
  logic        mus_ystb;
  logic        mus_btnstb;
  logic        err;

  modport master (
    output byte_in, byte_stb, byte_dst, frame_start,
    input  kbd_out, kbd_stb, mus_out, mus_xstb, mus_ystb, mus_btnstb, err
  );

  modport slave (
    input  byte_in, byte_stb, byte_dst, frame_start,
    output kbd_out, kbd_stb, mus_out, mus_xstb, mus_ystb, mus_btnstb, err
  );
endinterface

// File: rtl/kbdmus_mseq.sv
// Mouse emitter: X/Y staging, button-triggered 3-cycle X/Y/BTN strobe burst starting 1 cycle after the button byte.
// No backpressure; a button byte during a burst is held as a single pending snapshot (newest wins).
module kbdmus_mseq
  import kbdmus_pkg::*;
(
  input  logic       fclk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_stb,
  input  logic [1:0] byte_dst,
  output logic [7:0] mus_out,
  output logic       mus_xstb,
  output logic       mus_ystb,
  output logic       mus_btnstb
);
  logic [7:0] stg_x, stg_y;
  msnap_t     cur_q, pend_snap_q, snap, start_snap;
  logic       pend_q;
  logic [1:0] phase_q;  // burst cycle currently on the outputs, 0 = none
  logic       btn;

  assign btn        = byte_stb && (byte_dst == DST_MBTN);
  assign snap       = '{x: stg_x, y: stg_y, btn: byte_in};
  // A button byte landing on the final burst cycle is newer than any pending one.
  assign start_snap = btn ? snap : pend_snap_q;

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      stg_x       <= 8'h00;
      stg_y       <= 8'h00;
      cur_q       <= '0;
      pend_snap_q <= '0;
      pend_q      <= 1'b0;
      phase_q     <= 2'd0;
      mus_out     <= 8'h00;
      mus_xstb    <= 1'b0;
      mus_ystb    <= 1'b0;
      mus_btnstb  <= 1'b0;
    end else begin
      if (byte_stb && byte_dst == DST_MX) stg_x <= byte_in;
      if (byte_stb && byte_dst == DST_MY) stg_y <= byte_in;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      case (phase_q)
        2'd1: begin
          mus_out  <= cur_q.y;
          mus_ystb <= 1'b1;
          phase_q  <= 2'd2;
        end
        2'd2: begin
          mus_out    <= cur_q.btn;
          mus_btnstb <= 1'b1;
          phase_q    <= 2'd3;
        end
        default: begin
          if (btn || pend_q) begin
            cur_q    <= start_snap;
            mus_out  <= start_snap.x;
            mus_xstb <= 1'b1;
            phase_q  <= 2'd1;
            pend_q   <= 1'b0;
          end else begin
            phase_q <= 2'd0;
          end
        end
      endcase
      if (btn && (phase_q == 2'd1 || phase_q == 2'd2)) begin
        pend_q      <= 1'b1;
        pend_snap_q <= snap;
      end
    end
  end
endmodule

// File: rtl/kbdmus_loader.sv
// Assembles 5-byte keyboard frames into kbd_out (kbd_stb 1 cycle after last byte) and feeds the mouse emitter.
// No backpressure; stray bytes and inter-byte timeouts raise a one-cycle err.
module kbdmus_loader
  import kbdmus_pkg::*;
#(
  parameter int TIMEOUT   = 4096,
  parameter int KBD_BYTES = kbdmus_pkg::KBD_BYTES
) (
  input logic      fclk,
  input logic      rst,
  kbdmus_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  kstate_e       state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [39:0]   asm_q, asm_d, kbd_q, kbd_d;
  logic          kstb_q, kstb_d, err_q, err_d;
  logic          kbd_byte;

  assign kbd_byte = bus.byte_stb && (bus.byte_dst == DST_KBD);

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state_q <= KS_IDLE;
      cnt_q   <= 3'd0;
      tmo_q   <= '0;
      asm_q   <= 40'h0;
      kbd_q   <= 40'h0;
      kstb_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      asm_q   <= asm_d;
      kbd_q   <= kbd_d;
      kstb_q  <= kstb_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    asm_d   = asm_q;
    kbd_d   = kbd_q;
    kstb_d  = 1'b0;
    err_d   = 1'b0;
    if (kbd_byte && bus.frame_start) begin
      // A restart silently discards any partial frame.
      asm_d[7:0] = bus.byte_in;
      cnt_d      = 3'd1;
      tmo_d      = '0;
      state_d    = KS_COLLECT;
    end else if (kbd_byte) begin
      if (state_q == KS_COLLECT) begin
        for (int i = 1; i < KBD_BYTES; i++)
          if (cnt_q == 3'(i)) asm_d[8*i +: 8] = bus.byte_in;
        tmo_d = '0;
        if (cnt_q == 3'(KBD_BYTES - 1)) begin
          kbd_d   = asm_d;
          kstb_d  = 1'b1;
          cnt_d   = 3'd0;
          state_d = KS_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == KS_COLLECT) begin
      if (tmo_q == TW'(TIMEOUT - 1)) begin
        err_d   = 1'b1;
        tmo_d   = '0;
        cnt_d   = 3'd0;
        state_d = KS_IDLE;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  assign bus.kbd_out = kbd_q;
  assign bus.kbd_stb = kstb_q;
  assign bus.err     = err_q;

  kbdmus_mseq u_mseq (
    .fclk       (fclk),
    .rst        (rst),
    .byte_in    (bus.byte_in),
    .byte_stb   (bus.byte_stb),
    .byte_dst   (bus.byte_dst),
    .mus_out    (bus.mus_out),
    .mus_xstb   (bus.mus_xstb),
    .mus_ystb   (bus.mus_ystb),
    .mus_btnstb (bus.mus_btnstb)
  );
endmodule
